// File: rtl/ofc_pkg.sv
// Shared types and constants for the OFC frame-synchronisation slice.
package ofc_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam logic [1:0]  HDR_MARK    = 2'b11;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // One forwarded payload beat with its framing markers
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sop;
        logic              eop;
    } pkt_t;

    // True when a link word carries the header marker in its top two bits
    function automatic logic is_hdr(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 2] == HDR_MARK;
    endfunction

endpackage

// File: rtl/package_frame_ctrl_if.sv
// Link-word input and framed-packet output bundle of the frame controller.
interface package_frame_ctrl_if;
    import ofc_pkg::*;

    logic [WORD_W-1:0]      din;
    logic                   din_valid;
    logic [WORD_W-1:0]      pkt_data;
    logic                   pkt_valid;
    logic                   pkt_sop;
    logic                   pkt_eop;
    logic                   locked;
    logic                   hdr_miss;
    logic                   lock_lost;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // Link side / observer: drives words, watches packets and status
    modport master (
        output din, din_valid,
        input  pkt_data, pkt_valid, pkt_sop, pkt_eop,
        input  locked, hdr_miss, lock_lost, frame_cnt
    );

    // Frame controller side
    modport slave (
        input  din, din_valid,
        output pkt_data, pkt_valid, pkt_sop, pkt_eop,
        output locked, hdr_miss, lock_lost, frame_cnt
    );

endinterface

// File: rtl/header_window.sv
// Header-detection window: shift register of the most recent valid words
// plus a match that already includes the word arriving this cycle.
module header_window
    import ofc_pkg::*;
#(
    parameter int unsigned HDR_WORDS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] i_din,
    input  logic              i_valid,
    output logic              o_match_c
);

    logic [WORD_W-1:0] r_win [HDR_WORDS];

    // Shift on valid words only, newest in position 0; reset clears to a non-header pattern
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HDR_WORDS; i++) begin
                r_win[i] <= '0;
            end
        end else if (i_valid) begin
            r_win[0] <= i_din;
            for (int unsigned i = 1; i < HDR_WORDS; i++) begin
                r_win[i] <= r_win[i-1];
            end
        end
    end

    // Window after this word shifts in: current din plus the newest HDR_WORDS-1 stored words
    always_comb begin
        o_match_c = is_hdr(i_din);
        for (int unsigned i = 0; i + 1 < HDR_WORDS; i++) begin
            if (!is_hdr(r_win[i])) begin
                o_match_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/package_frame_ctrl.sv
// Frame-synchronisation controller: hunts for the header, verifies its
// periodicity, then forwards each frame's payload as a framed packet.
module package_frame_ctrl
    import ofc_pkg::*;
#(
    parameter int unsigned HDR_WORDS     = 6,
    parameter int unsigned PAYLOAD_WORDS = 64,
    parameter int unsigned LOCK_CNT      = 2,
    parameter int unsigned MISS_CNT      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    package_frame_ctrl_if.slave  bus
);

    localparam int unsigned PERIOD = HDR_WORDS + PAYLOAD_WORDS;
    localparam int unsigned CNT_W  = $clog2(PERIOD);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(MISS_CNT + 1);

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  LAST_PAY  = CNT_W'(PAYLOAD_WORDS - 1);
    localparam logic [CNT_W-1:0]  PAY_LEN   = CNT_W'(PAYLOAD_WORDS);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(MISS_CNT);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       r_word_cnt;
    logic [CNT_W-1:0]       w_word_cnt_nxt;
    logic [GOOD_W-1:0]      r_good_cnt;
    logic [GOOD_W-1:0]      w_good_cnt_nxt;
    logic [MISS_W-1:0]      r_miss_cnt;
    logic [MISS_W-1:0]      w_miss_cnt_nxt;
    pkt_t                   r_pkt;
    pkt_t                   w_pkt_nxt;
    logic                   r_pkt_valid;
    logic                   w_pkt_valid_nxt;
    logic                   r_locked;
    logic                   w_locked_nxt;
    logic                   r_hdr_miss;
    logic                   w_hdr_miss_nxt;
    logic                   r_lock_lost;
    logic                   w_lock_lost_nxt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [FRAME_CNT_W-1:0] w_frame_cnt_nxt;

    logic                   w_match;
    logic                   w_check;
    logic [GOOD_W-1:0]      w_good_inc;
    logic [MISS_W-1:0]      w_miss_inc;

    header_window #(
        .HDR_WORDS (HDR_WORDS)
    ) u_header_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_din     (bus.din),
        .i_valid   (bus.din_valid),
        .o_match_c (w_match)
    );

    assign w_check    = (r_word_cnt == LAST_WORD);
    assign w_good_inc = r_good_cnt + 1'b1;
    assign w_miss_inc = r_miss_cnt + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: transitions only on valid words; lock decisions only at the check point
    always_comb begin
        w_state_nxt = r_state;
        if (bus.din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (w_match) begin
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_check) begin
                        if (!w_match) begin
                            w_state_nxt = HUNT;
                        end else if (w_good_inc >= GOOD_LOCK) begin
                            w_state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (w_check && !w_match && (w_miss_inc >= MISS_DROP)) begin
                        w_state_nxt = HUNT;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Counter updates and registered-output next values
    always_comb begin
        w_word_cnt_nxt  = r_word_cnt;
        w_good_cnt_nxt  = r_good_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_pkt_nxt       = '0;
        w_pkt_valid_nxt = 1'b0;
        w_hdr_miss_nxt  = 1'b0;
        w_lock_lost_nxt = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_locked_nxt    = (w_state_nxt == LOCKED);

        if (bus.din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (w_match) begin
                        w_word_cnt_nxt = '0;
                        w_good_cnt_nxt = GOOD_W'(1);
                    end
                end
                VERIFY: begin
                    if (w_check) begin
                        w_word_cnt_nxt = '0;
                        if (w_match) begin
                            w_good_cnt_nxt = w_good_inc;
                            w_miss_cnt_nxt = '0;
                        end else begin
                            w_good_cnt_nxt = '0;
                        end
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (r_word_cnt < PAY_LEN) begin
                        w_pkt_valid_nxt = 1'b1;
                        w_pkt_nxt.data  = bus.din;
                        w_pkt_nxt.sop   = (r_word_cnt == '0);
                        w_pkt_nxt.eop   = (r_word_cnt == LAST_PAY);
                        if (r_word_cnt == LAST_PAY) begin
                            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                        end
                    end
                    if (w_check) begin
                        w_word_cnt_nxt = '0;
                        if (w_match) begin
                            w_miss_cnt_nxt = '0;
                        end else begin
                            w_hdr_miss_nxt = 1'b1;
                            w_miss_cnt_nxt = w_miss_inc;
                            if (w_miss_inc >= MISS_DROP) begin
                                w_lock_lost_nxt = 1'b1;
                            end
                        end
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
                default: w_word_cnt_nxt = '0;
            endcase
        end
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_cnt  <= '0;
            r_good_cnt  <= '0;
            r_miss_cnt  <= '0;
            r_pkt       <= '0;
            r_pkt_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_hdr_miss  <= 1'b0;
            r_lock_lost <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_word_cnt  <= w_word_cnt_nxt;
            r_good_cnt  <= w_good_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_pkt       <= w_pkt_nxt;
            r_pkt_valid <= w_pkt_valid_nxt;
            r_locked    <= w_locked_nxt;
            r_hdr_miss  <= w_hdr_miss_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign bus.pkt_data  = r_pkt.data;
    assign bus.pkt_sop   = r_pkt.sop;
    assign bus.pkt_eop   = r_pkt.eop;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.locked    = r_locked;
    assign bus.hdr_miss  = r_hdr_miss;
    assign bus.lock_lost = r_lock_lost;
    assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_package_frame_ctrl.sv
// Directed bench for package_frame_ctrl with a 6-word header and 4-word payload.
module tb_package_frame_ctrl;
    import ofc_pkg::*;

    localparam int HW = 6;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [15:0] q_data [$];
    logic        q_sop  [$];
    logic        q_eop  [$];
    int          miss_pulses = 0;
    int          lost_pulses = 0;

    always #5 clk = ~clk;

    package_frame_ctrl_if bus ();

    package_frame_ctrl #(
        .HDR_WORDS     (HW),
        .PAYLOAD_WORDS (PW),
        .LOCK_CNT      (2),
        .MISS_CNT      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one word, clock it in, sample outputs 1 time unit after the edge
    task automatic step(input logic [15:0] d, input logic v);
        bus.din       = d;
        bus.din_valid = v;
        @(posedge clk);
        #1;
        if (bus.pkt_valid === 1'b1) begin
            q_data.push_back(bus.pkt_data);
            q_sop.push_back(bus.pkt_sop);
            q_eop.push_back(bus.pkt_eop);
        end
        if (bus.hdr_miss === 1'b1) miss_pulses++;
        if (bus.lock_lost === 1'b1) lost_pulses++;
        if (!v) chk("idle_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    endtask

    // Header (optionally one word corrupted to 0x3FFF) then payload 1..PW
    task automatic frame(input int bad_idx, input bit gap);
        for (int i = 0; i < HW; i++) begin
            step((i == bad_idx) ? 16'h3FFF : 16'hC000, 1'b1);
            if (gap) step(16'h0000, 1'b0);
        end
        for (int p = 1; p <= PW; p++) begin
            step(16'(p), 1'b1);
            if (gap) step(16'h0000, 1'b0);
        end
    endtask

    task automatic clear_log();
        q_data.delete();
        q_sop.delete();
        q_eop.delete();
        miss_pulses = 0;
        lost_pulses = 0;
    endtask

    task automatic check_packets(input string tag, input int nframes);
        int n;
        n = nframes * PW;
        chk({tag, "_count"}, 32'(q_data.size()), 32'(n));
        for (int k = 0; k < n && k < q_data.size(); k++) begin
            int p;
            p = k % PW;
            chk({tag, "_data"}, 32'(q_data[k]), 32'(p + 1));
            chk({tag, "_sop"},  32'(q_sop[k]),  32'(p == 0));
            chk({tag, "_eop"},  32'(q_eop[k]),  32'(p == PW - 1));
        end
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;

        // Reset with random input activity
        rst_n = 1'b0;
        repeat (5) step(16'($urandom), 1'($urandom));
        chk("rst_pkt_data",  32'(bus.pkt_data),  32'd0);
        chk("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("rst_pkt_sop",   32'(bus.pkt_sop),   32'd0);
        chk("rst_pkt_eop",   32'(bus.pkt_eop),   32'd0);
        chk("rst_locked",    32'(bus.locked),    32'd0);
        chk("rst_hdr_miss",  32'(bus.hdr_miss),  32'd0);
        chk("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;
        clear_log();

        // Clean lock: 1st header enters VERIFY, 2nd header locks, 2nd frame's payload onward is forwarded
        frame(-1, 1'b0);
        chk("clean_locked_f1", 32'(bus.locked), 32'd0);
        chk("clean_nopkt_f1",  32'(q_data.size()), 32'd0);
        frame(-1, 1'b0);
        chk("clean_locked_f2", 32'(bus.locked), 32'd1);
        frame(-1, 1'b0);
        frame(-1, 1'b0);
        check_packets("clean", 3);
        chk("clean_frame_cnt", 32'(bus.frame_cnt), 32'd3);
        chk("clean_hdr_miss",  32'(miss_pulses), 32'd0);

        // False header: 6 x 0xFFFF enters VERIFY, failed check returns to HUNT
        rst_n = 1'b0;
        step(16'h0000, 1'b0);
        rst_n = 1'b1;
        clear_log();
        chk("fh_frame_cnt_rst", 32'(bus.frame_cnt), 32'd0);
        repeat (HW) step(16'hFFFF, 1'b1);
        repeat (10) step(16'h0000, 1'b1);
        chk("fh_locked",  32'(bus.locked), 32'd0);
        chk("fh_nopkt",   32'(q_data.size()), 32'd0);
        frame(-1, 1'b0);
        chk("fh_relock_f1", 32'(bus.locked), 32'd0);
        frame(-1, 1'b0);
        chk("fh_relock_f2", 32'(bus.locked), 32'd1);
        chk("fh_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        // Flywheel: three corrupted headers, first two frames still delivered, third drops lock
        clear_log();
        frame(2, 1'b0);
        chk("fly_locked_m1", 32'(bus.locked), 32'd1);
        frame(2, 1'b0);
        chk("fly_locked_m2", 32'(bus.locked), 32'd1);
        frame(2, 1'b0);
        chk("fly_locked_m3", 32'(bus.locked), 32'd0);
        chk("fly_hdr_miss",  32'(miss_pulses), 32'd3);
        chk("fly_lock_lost", 32'(lost_pulses), 32'd1);
        check_packets("fly", 2);
        chk("fly_frame_cnt", 32'(bus.frame_cnt), 32'd3);
        frame(-1, 1'b0);
        chk("fly_frame_cnt_stop", 32'(bus.frame_cnt), 32'd3);
        chk("fly_locked_after",   32'(bus.locked), 32'd0);
        chk("fly_lost_once",      32'(lost_pulses), 32'd1);

        // Gapped input: valid on every other cycle gives the same packet sequence
        rst_n = 1'b0;
        step(16'h0000, 1'b0);
        rst_n = 1'b1;
        clear_log();
        frame(-1, 1'b1);
        chk("gap_locked_f1", 32'(bus.locked), 32'd0);
        frame(-1, 1'b1);
        chk("gap_locked_f2", 32'(bus.locked), 32'd1);
        frame(-1, 1'b1);
        frame(-1, 1'b1);
        check_packets("gap", 3);
        chk("gap_frame_cnt", 32'(bus.frame_cnt), 32'd3);

        // Reset during payload word 0x0002 of a locked frame
        clear_log();
        repeat (HW) step(16'hC000, 1'b1);
        step(16'h0001, 1'b1);
        chk("mid_sop_seen", 32'(q_sop.size() == 1 && q_sop[0] == 1'b1), 32'd1);
        rst_n = 1'b0;
        step(16'h0002, 1'b1);
        chk("mid_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("mid_pkt_eop",   32'(bus.pkt_eop),   32'd0);
        chk("mid_pkt_data",  32'(bus.pkt_data),  32'd0);
        chk("mid_locked",    32'(bus.locked),    32'd0);
        chk("mid_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;
        step(16'h0003, 1'b1);
        step(16'h0004, 1'b1);
        chk("mid_no_tail", 32'(q_data.size()), 32'd1);
        clear_log();
        frame(-1, 1'b0);
        chk("mid_relock_f1", 32'(bus.locked), 32'd0);
        frame(-1, 1'b0);
        chk("mid_relock_f2", 32'(bus.locked), 32'd1);
        check_packets("mid", 1);
        chk("mid_frame_cnt_after", 32'(bus.frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
